// File: rtl/serdes_pkg.sv
// Shared definitions for the serial link endpoints (p2s transmitter, s2p receiver).
// Bit-order selectors and the handshake-side tags live here so both ends agree.
package serdes_pkg;

  localparam bit LSB_FIRST = 1'b0;
  localparam bit MSB_FIRST = 1'b1;

  typedef enum logic {
    RX = 1'b0,
    TX = 1'b1
  } hs_side_e;

endpackage

// File: rtl/s2p.sv
// Serial-to-parallel receiver: gathers N handshaken serial bits into a word and
// presents it through a one-word holding register on a valid/ready port.
module s2p #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = serdes_pkg::LSB_FIRST
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  input  logic         s_data,
  output logic         s_ready,
  output logic         p_valid,
  output logic [N-1:0] p_data,
  input  logic         p_ready
);

  localparam int            CW   = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (N < 2) begin : g_bad_width
    $error("s2p: N must be at least 2");
  end

  logic [CW-1:0] count;
  logic [N-1:0]  shift_reg;
  logic [N-1:0]  shift_nxt;
  logic          accept;
  logic          word_done;

  // Shifted value including the bit arriving this cycle; also what a completing word loads.
  always_comb begin
    shift_nxt = shift_reg;
    if (MSB_FIRST == serdes_pkg::MSB_FIRST) begin
      shift_nxt = {shift_reg[N-2:0], s_data};
    end else begin
      shift_nxt = {s_data, shift_reg[N-1:1]};
    end
  end

  // Only the final bit of a word is held off while the previous word is unclaimed;
  // built from registers alone so p_ready never reaches s_ready combinationally.
  assign s_ready   = !(p_valid && (count == LAST));
  assign accept    = s_valid && s_ready;
  assign word_done = accept && (count == LAST);

  // NOTE: sequential state is written with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      shift_reg <= '0;
      p_data    <= '0;
      p_valid   <= 1'b0;
    end else begin
      if (accept) begin
        shift_reg <= shift_nxt;
        count     <= word_done ? '0 : count + 1'b1;
      end
      // A completing word wins over a same-edge output handshake.
      if (word_done) begin
        p_data  <= shift_nxt;
        p_valid <= 1'b1;
      end else if (p_valid && p_ready) begin
        p_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_s2p.sv
// Bench for s2p: both bit orders side by side, directed cases plus random traffic
// and a behavioural p2s loopback, checked through an expected-word scoreboard.
module tb_s2p;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_valid;
  logic         s_data;
  logic         p_ready;
  logic         s_ready0, s_ready1;
  logic         p_valid0, p_valid1;
  logic [N-1:0] p_data0, p_data1;

  always #5 clk = ~clk;

  s2p #(.N(N), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready0),
    .p_valid(p_valid0), .p_data(p_data0), .p_ready(p_ready)
  );

  s2p #(.N(N), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready1),
    .p_valid(p_valid1), .p_data(p_data1), .p_ready(p_ready)
  );

  int           vectors     = 0;
  int           miscompares = 0;
  int           stalls      = 0;
  int           words_seen  = 0;
  bit           rand_ready  = 1'b0;
  logic [N-1:0] exp0[$];
  logic [N-1:0] exp1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collect accepted bits; every N of them form a word whose
  // bit i is the i-th bit received (LSB-first) or bit N-1-i (MSB-first).
  bit           bits[$];
  logic [N-1:0] w_lsb, w_msb;

  always @(negedge clk) begin
    if (rst) begin
      bits.delete();
      exp0.delete();
      exp1.delete();
    end else if (s_valid && s_ready0) begin
      bits.push_back(s_data);
      if (bits.size() == N) begin
        for (int i = 0; i < N; i++) begin
          w_lsb[i]       = bits[i];
          w_msb[N-1-i]   = bits[i];
        end
        exp0.push_back(w_lsb);
        exp1.push_back(w_msb);
        bits.delete();
      end
    end
  end

  // Monitor: pop and compare on each output handshake; check hold stability.
  logic         hold0 = 1'b0, hold1 = 1'b0;
  logic [N-1:0] held0, held1;

  always @(negedge clk) begin
    if (rst) begin
      hold0 = 1'b0;
      hold1 = 1'b0;
    end else begin
      if (hold0) begin
        check("dut0 p_valid held", p_valid0, 1);
        check("dut0 p_data stable", p_data0, held0);
      end
      if (hold1) begin
        check("dut1 p_valid held", p_valid1, 1);
        check("dut1 p_data stable", p_data1, held1);
      end
      if (p_valid0 && p_ready) begin
        vectors++;
        if (exp0.size() == 0) begin
          miscompares++;
          $display("FAIL dut0 unexpected word: got %0h expected none at %0t", p_data0, $time);
        end else begin
          vectors--;
          check("dut0 word", p_data0, exp0.pop_front());
          words_seen++;
        end
      end
      if (p_valid1 && p_ready) begin
        vectors++;
        if (exp1.size() == 0) begin
          miscompares++;
          $display("FAIL dut1 unexpected word: got %0h expected none at %0t", p_data1, $time);
        end else begin
          vectors--;
          check("dut1 word", p_data1, exp1.pop_front());
        end
      end
      hold0 = p_valid0 && !p_ready;
      hold1 = p_valid1 && !p_ready;
      held0 = p_data0;
      held1 = p_data1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) p_ready = 1'($urandom_range(0, 1));
  endtask

  // Present one bit and hold it until it is accepted (bounded wait).
  task automatic send_bit(input logic b);
    int waited = 0;
    bit ok;
    s_valid = 1'b1;
    s_data  = b;
    forever begin
      ok = s_ready0;
      tick();
      if (ok) break;
      stalls++;
      waited++;
      if (waited > 200) begin
        vectors++;
        miscompares++;
        $display("FAIL s_ready timeout: got 0 expected 1 at %0t", $time);
        break;
      end
    end
  endtask

  // Behavioural p2s: LSB-first serialisation paced by s_ready.
  task automatic send_word(input logic [N-1:0] w);
    for (int i = 0; i < N; i++) send_bit(w[i]);
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_data  = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n = 0;
    while ((exp0.size() != 0 || p_valid0) && n < 100) begin
      tick();
      n++;
    end
    check("drain within bound", 32'(n < 100), 1);
  endtask

  int           base;
  logic [N-1:0] rw;
  logic [N-1:0] ones = '1;

  initial begin
    s_valid = 1'b0;
    s_data  = 1'b0;
    p_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("reset p_valid0", p_valid0, 0);
    check("reset p_data0", p_data0, 0);
    check("reset s_ready0", s_ready0, 1);
    check("reset s_ready1", s_ready1, 1);

    // A5 stream, both orders; valid for exactly one cycle
    send_word(8'hA5);
    idle();
    check("A5 latency p_valid0", p_valid0, 1);
    check("A5 lsb p_data0", p_data0, 8'hA5);
    check("A5 msb p_data1", p_data1, 8'hA5);
    tick();
    check("A5 one-cycle p_valid0", p_valid0, 0);

    send_word(8'h01);
    idle();
    check("01 lsb p_data0", p_data0, 8'h01);
    check("01 msb p_data1", p_data1, 8'h80);
    tick();

    // Backpressure: second word's last bit stalls until 3C is taken
    p_ready = 1'b0;
    send_word(8'h3C);
    for (int i = 0; i < N - 1; i++) send_bit(1'(8'hC3 >> i));
    s_valid = 1'b1;
    s_data  = 1'b1;
    check("bp s_ready0 low", s_ready0, 0);
    check("bp p_data0 held", p_data0, 8'h3C);
    tick();
    tick();
    check("bp s_ready0 still low", s_ready0, 0);
    check("bp p_data1 held", p_data1, 8'h3C);
    p_ready = 1'b1;
    tick();
    check("bp handshake p_valid0", p_valid0, 0);
    check("bp s_ready0 reopened", s_ready0, 1);
    tick();
    idle();
    check("bp C3 p_valid0", p_valid0, 1);
    check("bp C3 p_data0", p_data0, 8'hC3);
    check("bp C3 p_data1", p_data1, 8'hC3);
    tick();

    // Reset mid-word discards the partial word
    for (int i = 0; i < 5; i++) send_bit(ones[i]);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid-word rst p_valid0", p_valid0, 0);
    send_word(8'h5A);
    idle();
    check("post-rst p_data0", p_data0, 8'h5A);
    check("post-rst p_data1", p_data1, 8'h5A);
    tick();

    // Reset drops a held word
    p_ready = 1'b0;
    send_word(8'hE7);
    idle();
    check("held E7 p_valid0", p_valid0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst drops p_valid0", p_valid0, 0);
    check("rst clears p_data0", p_data0, 0);
    p_ready = 1'b1;

    // Random traffic: gapped s_valid, random p_ready
    base       = words_seen;
    rand_ready = 1'b1;
    for (int w = 0; w < 16; w++) begin
      rw = N'($urandom);
      for (int i = 0; i < N; i++) begin
        while ($urandom_range(0, 1) == 1) begin
          idle();
          tick();
        end
        send_bit(rw[i]);
      end
    end
    idle();
    rand_ready = 1'b0;
    p_ready    = 1'b1;
    drain();
    check("random words received", words_seen - base, 16);

    // Loopback: 256 words streamed back to back, no stalls allowed
    stalls = 0;
    base   = words_seen;
    for (int w = 0; w < 256; w++) send_word(N'(w));
    idle();
    drain();
    check("loopback stall cycles", stalls, 0);
    check("loopback words received", words_seen - base, 256);
    check("scoreboard empty", exp0.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
